// File: rtl/tt_um_rs_bcd2bin.sv
// Sequential 3-digit BCD-to-binary converter (reverse double-dabble, 10 iterations).
// Optional macro RS_START_SYNC_EN adds a 2-flop synchronizer on the start pin.
module tt_um_rs_bcd2bin (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_start_q;
  logic [11:0] r_bcd;
  logic [9:0]  r_bin;
  logic        r_invalid;
  logic [9:0]  r_result;
  logic        r_done;

  logic        w_start;
  logic        w_edge;
  logic        w_digit_bad;
  logic [21:0] w_shift;
  logic [11:0] w_bcd_adj;
  logic        w_unused;

`ifdef RS_START_SYNC_EN
  logic [1:0] r_sync;

  // Synchronizer runs regardless of ena so a pulse on the pin is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], uio_in[4]};
    end
  end

  assign w_start = r_sync[1];
`else
  assign w_start = uio_in[4];
`endif

  assign w_edge      = w_start & ~r_start_q;
  assign w_digit_bad = (uio_in[3:0] > 4'd9) | (ui_in[7:4] > 4'd9) | (ui_in[3:0] > 4'd9);
  assign w_shift     = {r_bcd, r_bin} >> 1;

  // After the shift, every BCD digit that reached 8 or more is pulled back by 3.
  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    assign w_bcd_adj[gi*4 +: 4] = (w_shift[10 + gi*4 +: 4] >= 4'd8)
                                  ? w_shift[10 + gi*4 +: 4] - 4'd3
                                  : w_shift[10 + gi*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_start_q <= 1'b0;
      r_bcd     <= 12'd0;
      r_bin     <= 10'd0;
      r_invalid <= 1'b0;
      r_result  <= 10'd0;
      r_done    <= 1'b0;
    end else if (ena) begin
      r_start_q <= w_start;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_edge) begin
            r_state   <= S_CONV;
            r_bcd     <= {uio_in[3:0], ui_in};
            r_bin     <= 10'd0;
            r_cnt     <= 4'd0;
            r_invalid <= w_digit_bad;
            r_done    <= 1'b0;
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_adj;
          r_bin <= w_shift[9:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd9) begin
            r_state  <= S_DONE;
            r_result <= r_invalid ? 10'h3FF : w_shift[9:0];
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uo_out   = r_result[7:0];
  assign uio_out  = {r_done, r_result[9], r_result[8], 5'b00000};
  assign uio_oe   = 8'hE0;
  assign w_unused = &{1'b0, uio_in[7:5]};

endmodule
